// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Decode-stage hazard unit for the pipelined WISC core. Each architectural
// register owns a small countdown holding the number of cycles a dependent
// reader must still wait before the in-flight value of that register can be
// consumed. A decode stall is raised while any source register the decode
// instruction actually reads still has a non-zero countdown.
//
// Ports:
//   clk           - clock, all state updates on the rising edge
//   rst_n         - asynchronous reset, active low
//   id_valid      - decode stage holds a real instruction
//   id_rs/_used   - first source index / instruction reads it
//   id_rt/_used   - second source index / instruction reads it
//   id_rd         - destination index
//   id_reg_write  - instruction writes id_rd
//   id_is_load    - instruction is a memory load
//   flush         - decode instruction squashed this cycle
//   pipe_freeze   - whole pipeline held (memory stall)
//   stall         - hold fetch/decode, bubble into execute (combinational)
//   busy_vec      - bit r set while register r has a pending countdown
//   stall_cycles  - saturating count of hazard stall cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS    = 8,
    parameter int REG_W       = 3,
    parameter int FWD_EN      = 0,
    parameter int WB_DIST     = 2,
    parameter int ALU_LAT     = 0,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_REG_EN = 0,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rs,
    input  logic                id_rs_used,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                id_rt_used,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                id_reg_write,
    input  logic                id_is_load,
    input  logic                flush,
    input  logic                pipe_freeze,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam int MAX_AB  = (WB_DIST > ALU_LAT) ? WB_DIST : ALU_LAT;
    localparam int MAX_LAT = (MAX_AB > LOAD_LAT) ? MAX_AB : LOAD_LAT;
    // Keep at least one bit so an all-zero-latency build still elaborates.
    localparam int LAT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    localparam logic [LAT_W-1:0] WB_LAT_C   = LAT_W'(WB_DIST);
    localparam logic [LAT_W-1:0] ALU_LAT_C  = LAT_W'(ALU_LAT);
    localparam logic [LAT_W-1:0] LOAD_LAT_C = LAT_W'(LOAD_LAT);
    localparam logic [LAT_W-1:0] LAT_ZERO   = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);
    localparam logic [CNT_W-1:0] STALL_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STALL_ONE  = CNT_W'(1);

    logic [LAT_W-1:0] r_cnt [NUM_REGS];
    logic [CNT_W-1:0] r_stall_cycles;

    logic             w_hz_rs;
    logic             w_hz_rt;
    logic             w_stall;
    logic             w_issue;
    logic [LAT_W-1:0] w_lat;

    // Register 0 is never tracked when it is hardwired to zero.
    function automatic logic is_tracked(input logic [REG_W-1:0] idx);
        return !((ZERO_REG_EN != 0) && (idx == {REG_W{1'b0}}));
    endfunction

    // A source is hazardous only if it is read, tracked and still pending.
    function automatic logic src_hazard(input logic             used,
                                        input logic [REG_W-1:0] idx,
                                        input logic [LAT_W-1:0] cnt_val);
        return used && (cnt_val != LAT_ZERO) && is_tracked(idx);
    endfunction

    // Hazard detection, stall, issue qualification and writer latency.
    always_comb begin
        w_hz_rs = src_hazard(id_rs_used, id_rs, r_cnt[id_rs]);
        w_hz_rt = src_hazard(id_rt_used, id_rt, r_cnt[id_rt]);
        w_stall = id_valid && !flush && (w_hz_rs || w_hz_rt);
        w_issue = id_valid && !w_stall && !flush && !pipe_freeze;
        if (FWD_EN != 0) begin
            if (id_is_load) begin
                w_lat = LOAD_LAT_C;
            end else begin
                w_lat = ALU_LAT_C;
            end
        end else begin
            w_lat = WB_LAT_C;
        end
    end

    // Per-register countdowns: freeze holds, a fresh writer reloads (the
    // youngest producer wins over an older pending count), else drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= LAT_ZERO;
            end
        end else if (!pipe_freeze) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_issue && id_reg_write && (id_rd == REG_W'(r)) && is_tracked(id_rd)) begin
                    r_cnt[r] <= w_lat;
                end else if (r_cnt[r] != LAT_ZERO) begin
                    r_cnt[r] <= r_cnt[r] - LAT_ONE;
                end else begin
                    r_cnt[r] <= r_cnt[r];
                end
            end
        end
    end

    // Saturating count of cycles lost to hazards; frozen cycles excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= {CNT_W{1'b0}};
        end else if (w_stall && !pipe_freeze && (r_stall_cycles != STALL_MAX)) begin
            r_stall_cycles <= r_stall_cycles + STALL_ONE;
        end
    end

    // Busy flags are a direct view of which countdowns are non-zero.
    always_comb begin
        busy_vec = {NUM_REGS{1'b0}};
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (r_cnt[r] != LAT_ZERO);
        end
    end

    // Output drive.
    always_comb begin
        stall        = w_stall;
        stall_cycles = r_stall_cycles;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// Bench for hazard_scoreboard. Two instances share one stimulus stream:
//   d0: no forwarding, WB_DIST=2, hardwired r0, 4-bit stall counter
//   d1: forwarding, ALU_LAT=0, LOAD_LAT=1, r0 tracked, 16-bit counter
// The reference model keeps, per register, the timestamp at which the value
// becomes consumable; time only advances on non-frozen edges.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_rs_used, id_rt_used, id_reg_write, id_is_load;
    logic       flush, pipe_freeze;
    logic [2:0] id_rs, id_rt, id_rd;

    logic        stall0, stall1;
    logic [7:0]  busy0, busy1;
    logic [3:0]  sc0;
    logic [15:0] sc1;

    hazard_scoreboard #(
        .NUM_REGS(8), .REG_W(3), .FWD_EN(0), .WB_DIST(2), .ALU_LAT(0),
        .LOAD_LAT(1), .ZERO_REG_EN(1), .CNT_W(4)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .flush(flush), .pipe_freeze(pipe_freeze),
        .stall(stall0), .busy_vec(busy0), .stall_cycles(sc0)
    );

    hazard_scoreboard #(
        .NUM_REGS(8), .REG_W(3), .FWD_EN(1), .WB_DIST(2), .ALU_LAT(0),
        .LOAD_LAT(1), .ZERO_REG_EN(0), .CNT_W(16)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .flush(flush), .pipe_freeze(pipe_freeze),
        .stall(stall1), .busy_vec(busy1), .stall_cycles(sc1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int   t_now = 0;
    int   ready0 [8];
    int   ready1 [8];
    int   msc0 = 0;
    int   msc1 = 0;
    logic last_stall0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rdy(input int d, input int r);
        return (d == 0) ? ready0[r] : ready1[r];
    endfunction

    function automatic logic m_stall(input int d);
        logic zero_hw;
        logic h_rs, h_rt;
        zero_hw = (d == 0);
        h_rs = id_rs_used && (t_now < rdy(d, int'(id_rs))) && !(zero_hw && id_rs == 3'd0);
        h_rt = id_rt_used && (t_now < rdy(d, int'(id_rt))) && !(zero_hw && id_rt == 3'd0);
        return id_valid && !flush && (h_rs || h_rt);
    endfunction

    function automatic logic [7:0] m_busy(input int d);
        logic [7:0] b;
        b = 8'h00;
        for (int r = 0; r < 8; r++) b[r] = (t_now < rdy(d, r));
        return b;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 8; r++) begin
            ready0[r] = 0;
            ready1[r] = 0;
        end
        msc0 = 0;
        msc1 = 0;
    endtask

    task automatic drive(input logic v, input logic rsu, input logic rtu, input logic wr,
                         input logic ld, input logic fl, input logic fz,
                         input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        id_valid = v;  id_rs_used = rsu; id_rt_used = rtu; id_reg_write = wr;
        id_is_load = ld; flush = fl; pipe_freeze = fz;
        id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    // One clock with current inputs: compare against the model, then advance it.
    task automatic cycle();
        logic s0, s1, iss0, iss1;
        int   lat1;
        #1;
        s0 = m_stall(0);
        s1 = m_stall(1);
        chk("stall_d0", {31'd0, stall0}, {31'd0, s0});
        chk("stall_d1", {31'd0, stall1}, {31'd0, s1});
        chk("busy_d0", {24'd0, busy0}, {24'd0, m_busy(0)});
        chk("busy_d1", {24'd0, busy1}, {24'd0, m_busy(1)});
        chk("stallcnt_d0", {28'd0, sc0}, msc0);
        chk("stallcnt_d1", {16'd0, sc1}, msc1);
        last_stall0 = stall0;
        iss0 = id_valid && !s0 && !flush && !pipe_freeze;
        iss1 = id_valid && !s1 && !flush && !pipe_freeze;
        lat1 = id_is_load ? 1 : 0;
        @(posedge clk);
        if (!pipe_freeze) begin
            if (iss0 && id_reg_write && id_rd != 3'd0) ready0[id_rd] = t_now + 1 + 2;
            if (iss1 && id_reg_write) ready1[id_rd] = t_now + 1 + lat1;
            if (s0 && msc0 < 15) msc0++;
            if (s1 && msc1 < 65535) msc1++;
            t_now++;
        end
        @(negedge clk);
    endtask

    // Hold current inputs until d0 stops stalling; n = stalled cycles seen.
    task automatic run_until_issue(output int n);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (!last_stall0) break;
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_stall_d0", {31'd0, stall0}, 32'd0);
        chk("rst_busy_d0", {24'd0, busy0}, 32'd0);
        chk("rst_cnt_d1", {16'd0, sc1}, 32'd0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       v, rsu, rtu, wr, ld;
        logic [2:0] rs, rt, rd;
        logic       e_st0, e_st1;
        logic [7:0] e_b0, e_b1;
        logic [3:0] e_sc0;
    } vec_t;

    vec_t tbl [15];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int n;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        m_reset();

        //            v    rsu   rtu   wr    ld    rs    rt    rd   st0   st1   b0      b1      sc0
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 3'd1, 1'b1, 1'b0, 8'h08, 8'h00, 4'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 3'd1, 1'b1, 1'b0, 8'h08, 8'h00, 4'd1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 3'd1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 8'h00, 8'h00, 4'd2};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 3'd1, 1'b1, 1'b1, 8'h04, 8'h04, 4'd2};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 3'd1, 1'b1, 1'b0, 8'h04, 8'h00, 4'd3};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 3'd1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd4};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 8'h00, 8'h00, 4'd4};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 3'd1, 1'b0, 1'b0, 8'h20, 8'h00, 4'd4};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 3'd1, 1'b1, 1'b0, 8'h20, 8'h00, 4'd4};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 3'd1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd5};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd5};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 1'b0, 1'b1, 8'h00, 8'h01, 4'd5};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd5};

        // Power-on reset with a hazard-looking instruction on the inputs.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd3, 3'd3);
        #2;
        chk("por_stall_d0", {31'd0, stall0}, 32'd0);
        chk("por_busy_d1", {24'd0, busy1}, 32'd0);
        chk("por_cnt_d0", {28'd0, sc0}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: back-to-back deps, load-use, unused source, r0.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].rsu, tbl[i].rtu, tbl[i].wr, tbl[i].ld, 1'b0, 1'b0,
                  tbl[i].rs, tbl[i].rt, tbl[i].rd);
            #1;
            chk($sformatf("tbl%0d_stall_d0", i), {31'd0, stall0}, {31'd0, tbl[i].e_st0});
            chk($sformatf("tbl%0d_stall_d1", i), {31'd0, stall1}, {31'd0, tbl[i].e_st1});
            chk($sformatf("tbl%0d_busy_d0", i), {24'd0, busy0}, {24'd0, tbl[i].e_b0});
            chk($sformatf("tbl%0d_busy_d1", i), {24'd0, busy1}, {24'd0, tbl[i].e_b1});
            chk($sformatf("tbl%0d_cnt_d0", i), {28'd0, sc0}, {28'd0, tbl[i].e_sc0});
            cycle();
        end

        // WAW: load r4 then ALU r4 one cycle later; reader waits 2 from the second.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd4);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd4);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 3'd1);
        run_until_issue(n);
        chk("waw_stall_len", n, 32'd2);

        // Freeze for 3 cycles with cnt[1]=2, then drain.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("frz_busy", {24'd0, busy0}, 32'h02);
            chk("frz_cnt", {28'd0, sc0}, 32'd0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd2);
        run_until_issue(n);
        chk("frz_then_stall_len", n, 32'd2);
        chk("frz_total_cnt", {28'd0, sc0}, 32'd2);

        // Flush with a live hazard: no stall, no issue of the r6 write.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 3'd6);
        #1;
        chk("flush_stall", {31'd0, stall0}, 32'd0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        #1;
        chk("flush_busy", {24'd0, busy0}, 32'h02);
        chk("flush_cnt", {28'd0, sc0}, 32'd2);
        cycle();

        // Saturation: self-dependent writer of r3 stalls 2 of every 3 cycles.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 3'd3);
        for (int i = 0; i < 30; i++) cycle();
        chk("sat_cnt_d0", {28'd0, sc0}, 32'd15);
        chk("sat_cnt_d1", {16'd0, sc1}, 32'd0);
        cycle();
        #2;
        chk("pre_rst_stall", {31'd0, stall0}, 32'd1);
        // Asynchronous reset mid-stall, away from any clock edge.
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", {31'd0, stall0}, 32'd0);
        chk("async_rst_busy", {24'd0, busy0}, 32'd0);
        chk("async_rst_cnt", {28'd0, sc0}, 32'd0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 7) == 0), 3'($urandom), 3'($urandom), 3'($urandom));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised decode-stage hazard unit for the pipelined WISC core.
- Keeps a per-register pending-write countdown, so it no longer needs a comparator per downstream stage. Raises a decode stall while any source register the instruction actually reads still has a write in flight.
- Supports a no-forwarding mode and a forwarding mode. In forwarding mode, ALU-to-ALU dependencies do not stall and load-use dependencies stall for a shorter, load-specific time.
- Adds an optional hardwired-zero register, flush/freeze handling, and a saturating stall-cycle counter for performance measurement.

Parameters:
- NUM_REGS, 8: number of architectural registers. Must be a power of 2.
- REG_W, 3: register index width. Equals log2(NUM_REGS).
- FWD_EN, 0: 1 = a forwarding network exists downstream; selects the ALU_LAT/LOAD_LAT latencies.
- WB_DIST, 2: stall cycles a back-to-back dependent needs when FWD_EN=0.
- ALU_LAT, 0: stall cycles after a non-load writer when FWD_EN=1.
- LOAD_LAT, 1: stall cycles after a load writer when FWD_EN=1.
- ZERO_REG_EN, 0: 1 = register 0 is hardwired zero; it is never tracked and never causes a stall.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous reset, active low.
- id_valid, input, 1: the decode stage holds a real instruction.
- id_rs, input, REG_W: first source register index.
- id_rs_used, input, 1: the instruction reads id_rs.
- id_rt, input, REG_W: second source register index.
- id_rt_used, input, 1: the instruction reads id_rt.
- id_rd, input, REG_W: destination register index.
- id_reg_write, input, 1: the instruction writes id_rd.
- id_is_load, input, 1: the instruction is a memory load.
- flush, input, 1: the decode instruction is squashed this cycle.
- pipe_freeze, input, 1: the whole pipeline is held (memory stall).
- stall, output, 1: hold fetch/decode and inject a bubble into execute.
- busy_vec, output, NUM_REGS: bit r is 1 while register r has cnt != 0.
- stall_cycles, output, CNT_W: saturating count of hazard stall cycles.

Behaviour:
- State:
  - cnt[r], one per register. Width = clog2(max(WB_DIST, ALU_LAT, LOAD_LAT) + 1).
  - stall_cycles.
- Reset (rst_n=0, asynchronous): all cnt = 0 and stall_cycles = 0. As a result stall = 0 and busy_vec = 0 for as long as reset is held, regardless of the other inputs.
- Source-register hazard, evaluated separately for rs and rt:
  - hz_rs = id_rs_used & (cnt[id_rs] != 0) & ~(ZERO_REG_EN & id_rs == 0).
  - hz_rt is formed the same way from id_rt and id_rt_used.
- Stall output (combinational, zero latency from inputs): stall = id_valid & ~flush & (hz_rs | hz_rt).
- Issue (a decode instruction leaves decode this cycle): issue = id_valid & ~stall & ~flush & ~pipe_freeze.
- Latency selection: lat = FWD_EN ? (id_is_load ? LOAD_LAT : ALU_LAT) : WB_DIST.
- Per-register update at each clock edge, for every r, in priority order:
  1. pipe_freeze = 1: cnt[r] holds.
  2. issue & id_reg_write & (r == id_rd) & ~(ZERO_REG_EN & r == 0): cnt[r] <= lat. Issue beats decrement, and a newer writer overwrites an older pending count (WAW: the youngest producer governs). lat = 0 is written as 0.
  3. Otherwise, if cnt[r] != 0: cnt[r] decrements by 1.
- Timing consequence: a producer issues at edge t, so cnt = lat during cycle t+1. A dependent instruction in decode stalls for exactly lat cycles and issues in cycle t+1+lat.
- Self-dependency: an instruction whose rs equals its own rd only checks the cnt value from before its own issue.
- stall_cycles:
  - Increments when stall & ~pipe_freeze.
  - Saturates at 2^CNT_W - 1 and never wraps.
- Flush: forces stall = 0, blocks issue, and does not count a stall cycle. Counters still decrement (older instructions keep draining).
- Freeze: stall is still driven combinationally, but no state changes.
- A reset asserted mid-operation immediately clears all pending entries.

Test Plan:
1. FWD_EN=0, WB_DIST=2: issue ADD r3 at edge 0, then a dependent with rs=r3 in decode -> stall=1 in cycles 1 and 2, 0 in cycle 3; stall_cycles=2; busy_vec[3] set in cycles 1-2.
2. FWD_EN=1: ALU writer to r2 followed by a reader of r2 -> stall never asserts. Load to r2 followed by a reader of r2 -> stall=1 for exactly 1 cycle.
3. Reader with id_rt=r5 but id_rt_used=0 while cnt[5]=2 -> stall=0. Same reader with id_rt_used=1 -> stall=1.
4. WAW: load r4 issues (lat 2, FWD_EN=0), then an ALU op to r4 issues one cycle later -> cnt[4] reloads to 2 and the reader stalls 2 cycles from the second issue. ZERO_REG_EN=1: writes to r0 are never tracked -> reads of r0 never stall.
5. pipe_freeze held 3 cycles with cnt[1]=2 -> cnt, busy_vec, and stall_cycles unchanged. flush=1 with a hazard present -> stall=0 and nothing issues.
6. Force stall_cycles to its maximum value (CNT_W=4, 20 stall cycles) -> the count holds at 15. Drop rst_n mid-stall -> stall, busy_vec, and stall_cycles go to 0 immediately (asynchronously).
